edge_event_arbiter: RTL

- Multi-channel front end for pin edge detection.
- Each of N_CH asynchronous pins passes through a two-flop synchronizer and a high-to-low / low-to-high edge detector.
- Detected edges are latched as pending events; a round-robin scheduler serialises them onto one valid/ready event port consumed by the downstream pattern-detect sequencers.
- Per-channel sticky overrun flags report lost edges.

---
 rtl/edge_event_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/edge_event_arbiter.sv
// Multi-channel pin edge front end: synchronise, detect edges, latch pending events
// and serialise them round-robin onto a single valid/ready event port.
module edge_event_arbiter #(
    parameter int N_CH = 4,
    parameter int CH_W = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] pin_in,
    input  logic [N_CH-1:0] rise_en,
    input  logic [N_CH-1:0] fall_en,
    input  logic            evt_ready,
    output logic            evt_valid,
    output logic [CH_W-1:0] evt_ch,
    output logic            evt_rise,
    output logic [N_CH-1:0] overrun,
    input  logic            ovr_clr
);

    localparam logic [0:0]      ST_EMPTY = 1'b0;
    localparam logic [0:0]      ST_FULL  = 1'b1;
    localparam logic [N_CH-1:0] ONE_HOT0 = {{(N_CH-1){1'b0}}, 1'b1};

    logic [N_CH-1:0] sync1_r, sync2_r;
    logic [N_CH-1:0] fall_pend_r, rise_pend_r, rise_first_r, overrun_r;
    logic [CH_W-1:0] ptr_r, evt_ch_r;
    logic [0:0]      state_r;
    logic            evt_rise_r;

    logic [N_CH-1:0] fall_s, rise_s, req_s, sel_s;
    logic [N_CH-1:0] fall_take_s, rise_take_s, fall_keep_s, rise_keep_s;
    logic [N_CH-1:0] fall_new_s, rise_new_s, fall_ovr_s, rise_ovr_s;
    logic [CH_W-1:0] win_s, ptr_nxt_s;
    logic [CH_W:0]   idx_s;
    logic            found_s, win_rise_s, take_s;

    assign fall_s = sync2_r & ~sync1_r;
    assign rise_s = ~sync2_r & sync1_r;
    assign req_s  = fall_pend_r | rise_pend_r;

    // Round-robin search from the pointer, wrapping modulo N_CH
    always_comb begin
        win_s   = '0;
        found_s = 1'b0;
        idx_s   = '0;
        for (int i = 0; i < N_CH; i++) begin
            idx_s = {1'b0, ptr_r} + (CH_W+1)'(i);
            if (idx_s >= (CH_W+1)'(N_CH)) begin
                idx_s = idx_s - (CH_W+1)'(N_CH);
            end else begin
                idx_s = idx_s;
            end
            if (!found_s && req_s[idx_s[CH_W-1:0]]) begin
                found_s = 1'b1;
                win_s   = idx_s[CH_W-1:0];
            end else begin
                found_s = found_s;
            end
        end
    end

    // Winner type, consume decision and pending/order/overrun next-state terms
    always_comb begin
        win_rise_s = rise_pend_r[win_s] & (~fall_pend_r[win_s] | rise_first_r[win_s]);
        take_s     = found_s & ((state_r == ST_EMPTY) | evt_ready);
        if (take_s) begin
            sel_s = ONE_HOT0 << win_s;
        end else begin
            sel_s = '0;
        end
        if (win_s == CH_W'(N_CH - 1)) begin
            ptr_nxt_s = '0;
        end else begin
            ptr_nxt_s = win_s + CH_W'(1);
        end
        fall_take_s = sel_s & {N_CH{~win_rise_s}};
        rise_take_s = sel_s & {N_CH{win_rise_s}};
        // A consumed bit counts as free, so a same-cycle edge becomes a new event
        fall_keep_s = fall_pend_r & ~fall_take_s;
        rise_keep_s = rise_pend_r & ~rise_take_s;
        fall_new_s  = fall_s & fall_en & ~fall_keep_s;
        rise_new_s  = rise_s & rise_en & ~rise_keep_s;
        fall_ovr_s  = fall_s & fall_en & fall_keep_s;
        rise_ovr_s  = rise_s & rise_en & rise_keep_s;
    end

    // Two-flop synchronizer, idle high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= '1;
            sync2_r <= '1;
        end else begin
            sync1_r <= pin_in;
            sync2_r <= sync1_r;
        end
    end

    // Pending events, age order (1 = rise is older) and sticky overrun
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fall_pend_r  <= '0;
            rise_pend_r  <= '0;
            rise_first_r <= '0;
            overrun_r    <= '0;
        end else begin
            fall_pend_r  <= fall_keep_s | fall_new_s;
            rise_pend_r  <= rise_keep_s | rise_new_s;
            rise_first_r <= (rise_first_r & ~(rise_new_s & fall_keep_s)) | (fall_new_s & rise_keep_s);
            overrun_r    <= (overrun_r & ~{N_CH{ovr_clr}}) | fall_ovr_s | rise_ovr_s;
        end
    end

    // Output stage: load or reload the winner, hold while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_EMPTY;
            evt_ch_r   <= '0;
            evt_rise_r <= 1'b0;
            ptr_r      <= '0;
        end else if (take_s) begin
            state_r    <= ST_FULL;
            evt_ch_r   <= win_s;
            evt_rise_r <= win_rise_s;
            ptr_r      <= ptr_nxt_s;
        end else if ((state_r == ST_FULL) && evt_ready) begin
            state_r    <= ST_EMPTY;
        end else begin
            state_r    <= state_r;
        end
    end

    assign evt_valid = (state_r == ST_FULL);
    assign evt_ch    = evt_ch_r;
    assign evt_rise  = evt_rise_r;
    assign overrun   = overrun_r;

endmodule
